fpu16_addsub_issue: RTL and testbench
=====================================

// Module: fpu16_addsub_issue
// PURPOSE
//  Operand front-end and result collector for the 3-stage FP16 add/sub unit.
//  - Accepts operations over a valid/ready handshake.
//  - Screens out special operands, resolves them locally, and issues only normal x normal ops to the unit (au_* ports).
//  - Tracks ops in flight and returns results strictly in order through an output FIFO.
// PARAMETERS
//  DEPTH   4  output FIFO entries = max ops accepted but not yet popped (in flight + buffered); >= AU_LAT+1
//  AU_LAT  3  cycles from au_start high to au_done high (fixed by the add/sub unit)
// PORTS
//  CLK        in   1   clock, rising edge
//  RST        in   1   reset, synchronous, active-high
//  in_valid   in   1   op offered
//  in_ready   out  1   op accepted when in_valid & in_ready
//  in_a       in   16  FP16 operand A
//  in_b       in   16  FP16 operand B
//  in_sel     in   1   0 = A+B, 1 = A-B
//  au_ain     out  16  to unit Ain (registered)
//  au_bin     out  16  to unit Bin (registered)
//  au_select  out  1   to unit Select (registered)
//  au_start   out  1   to unit Start; one-cycle pulse per issued op
//  au_out     in   16  from unit Out
//  au_done    in   1   from unit Done; au_out valid this cycle
//  out_valid  out  1   result available (FIFO not empty)
//  out_ready  in   1   consumer pops head when out_valid & out_ready
//  out_data   out  16  FIFO head result
//  out_flags  out  3   {INV, OVF, SPC} for head; present only with FPU_FLAGS_EN
// BEHAVIOUR
//  - Reset values: au_* = 0, au_start = 0, out_valid = 0, in_ready = 0, FIFO empty, inflight = 0.
//  - Post-reset drain: the unit has no reset. After RST falls, a drain counter holds in_ready low for AU_LAT cycles.
//    au_done is ignored while RST is high and while draining. RST mid-operation discards all buffered and in-flight ops.
//  - Classification:
//    - effective B: eb = {in_b[15]^in_sel, in_b[14:0]}
//    - exp==0: zero (denormals flushed to zero)
//    - exp==31 & man!=0: NaN
//    - exp==31 & man==0: Inf
//  - Special results, in priority order:
//    - any NaN, or Inf + Inf with opposite effective signs -> 16'h7E00, INV
//    - one Inf -> that Inf with its effective sign, SPC
//    - A zero and eb zero -> {a_s & eb_s, 15'b0}, SPC
//    - A zero only -> eb; eb zero only -> in_a; SPC
//    - both normal -> issue to the unit
//  - Occupancy: occ = fifo_count + inflight.
//  - in_ready = ~RST & drain==0 & (occ < DEPTH) & (op_is_normal | inflight==0).
//    - Depends combinationally on in_a/in_b class, never on in_valid.
//    - A special op waits until the unit is empty, so results stay in order.
//  - Normal accept at edge T:
//    - au_ain/au_bin/au_select loaded, au_start = 1 for cycle T+1, inflight +1.
//    - au_done is expected in cycle T+1+AU_LAT; au_out is pushed at that edge; out_valid is high from the next cycle.
//    - Accept->out_valid latency = AU_LAT+2 (5 at default).
//  - Special accept at edge T: result pushed at that edge; out_valid is high in cycle T+1.
//  - Unit result post-fix: if au_out[14:10]==31, replace with {au_out[15], 5'h1F, 10'h0} and set OVF; otherwise flags = 0.
//  - Simultaneous events:
//    - issue and au_done in the same cycle: inflight unchanged.
//    - push and pop on a full FIFO: allowed, count unchanged.
//    - au_done with a full FIFO is impossible by the occupancy rule; an assertion checks it.
//  - Back-to-back normal ops issue every cycle (full throughput) while occ < DEPTH.
// CONFIGURATION
//  FPU_FLAGS_EN defined: out_flags port exists; 3 flag bits are stored per FIFO entry.
//  Not defined: no out_flags port and no flag storage. Data results are identical either way.
// STRUCTURE
//  Shared package fpu16_pkg:
//    - FP16_QNAN = 16'h7E00, FP16_EXP_MAX = 5'h1F
//    - flag bit indices FLG_INV/FLG_OVF/FLG_SPC
//    - operand class enum {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN}
//  Sub-module fpu16_result_fifo: DEPTH x (16 + flag bits), synchronous RST, push/pop/count.
//  Classifier, special resolver, inflight counter and drain counter stay in this module.
// TESTING
//  1. 3C00 + 3C00, sel=0 -> au_start 1 cycle after accept; out 4000 five cycles after accept; flags 000.
//  2. 3C00 - 3C00 -> out 0000; 4200 - 3C00 -> out 4000 (3.0 - 1.0).
//  3. 7C00 + FC00 -> 7E00, INV, out_valid 1 cycle after accept; au_start never pulses.
//  4. 7BFF + 7BFF -> 7C00, OVF.
//  5. Normal 3C00+3C00 then special 0000+4000 back-to-back -> in_ready low until inflight=0; outputs 4000 then 4000 in order.
//  6. out_ready=0, DEPTH=4, six normal ops offered -> in_ready drops after 4; release -> all six out, in order, none lost.
//  7. RST for 1 cycle with 2 ops in flight -> no outputs; in_ready low for 3 cycles after RST falls; stray au_done ignored.

Source files
------------

// File: rtl/fpu16_pkg.sv
// Shared FP16 definitions for the add/sub issue front-end: constants, flag
// bit positions and the operand classifier.
package fpu16_pkg;

  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

  localparam int NFLAGS  = 3;
  localparam int FLG_SPC = 0;
  localparam int FLG_OVF = 1;
  localparam int FLG_INV = 2;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp16_cls_e;

  // Denormals land in CLS_ZERO: the unit only ever sees normal operands.
  function automatic fp16_cls_e fp16_classify(input logic [15:0] v);
    if (v[14:10] == 5'd0) begin
      return CLS_ZERO;
    end else if (v[14:10] != FP16_EXP_MAX) begin
      return CLS_NORM;
    end else if (v[9:0] != 10'd0) begin
      return CLS_NAN;
    end else begin
      return CLS_INF;
    end
  endfunction

endpackage

// File: rtl/fpu16_addsub_issue_fifo.sv
// In-order result buffer for the FP16 add/sub front-end. Push and pop in the
// same cycle are allowed even when full.
module fpu16_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // When full, the slot under wr_ptr is the head being popped this cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu16_addsub_issue.sv
// Operand screen, issue and in-order result collection for the 3-stage FP16
// add/sub unit. Define FPU_FLAGS_EN to store and expose {INV, OVF, SPC} flags.
module fpu16_addsub_issue
  import fpu16_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int AU_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_sel,
  output logic [15:0] au_ain,
  output logic [15:0] au_bin,
  output logic        au_select,
  output logic        au_start,
  input  logic [15:0] au_out,
  input  logic        au_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
`ifdef FPU_FLAGS_EN
  ,
  output logic [NFLAGS-1:0] out_flags
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = (AU_LAT > 0) ? $clog2(AU_LAT + 1) : 1;
`ifdef FPU_FLAGS_EN
  localparam int EW = 16 + NFLAGS;
`else
  localparam int EW = 16;
`endif

  logic [15:0]       eb;
  fp16_cls_e         a_cls;
  fp16_cls_e         b_cls;
  logic              op_normal;
  logic [15:0]       spec_data;
  logic [NFLAGS-1:0] spec_flags;
  logic [15:0]       unit_data;
  logic [NFLAGS-1:0] unit_flags;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occ;
  logic [DW-1:0]     drain;
  logic              accept;
  logic              issue;
  logic              done_ok;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [15:0]       push_data;
  logic [NFLAGS-1:0] push_flags;
  logic [EW-1:0]     push_entry;
  logic [EW-1:0]     head_entry;

  assign eb        = {in_b[15] ^ in_sel, in_b[14:0]};
  assign a_cls     = fp16_classify(in_a);
  assign b_cls     = fp16_classify(eb);
  assign op_normal = (a_cls == CLS_NORM) && (b_cls == CLS_NORM);

  always_comb begin
    spec_data  = '0;
    spec_flags = '0;
    if (a_cls == CLS_NAN || b_cls == CLS_NAN ||
        (a_cls == CLS_INF && b_cls == CLS_INF && in_a[15] != eb[15])) begin
      spec_data           = FP16_QNAN;
      spec_flags[FLG_INV] = 1'b1;
    end else begin
      spec_flags[FLG_SPC] = 1'b1;
      if (a_cls == CLS_INF) begin
        spec_data = in_a;
      end else if (b_cls == CLS_INF) begin
        spec_data = eb;
      end else if (a_cls == CLS_ZERO && b_cls == CLS_ZERO) begin
        spec_data = {in_a[15] & eb[15], 15'b0};
      end else if (a_cls == CLS_ZERO) begin
        spec_data = eb;
      end else begin
        spec_data = in_a;
      end
    end
  end

  // The unit may leave a non-zero mantissa on overflow; clean it to Inf.
  always_comb begin
    unit_data  = au_out;
    unit_flags = '0;
    if (au_out[14:10] == FP16_EXP_MAX) begin
      unit_data           = {au_out[15], FP16_EXP_MAX, 10'h000};
      unit_flags[FLG_OVF] = 1'b1;
    end
  end

  assign occ      = {1'b0, fifo_count} + {1'b0, inflight};
  assign in_ready = ~rst && (drain == '0) && (occ < (CW + 1)'(DEPTH)) &&
                    (op_normal || inflight == '0);
  assign accept   = in_valid & in_ready;
  assign issue    = accept & op_normal;
  // Completions are only believed while an op is actually outstanding.
  assign done_ok  = au_done & ~rst & (drain == '0) & (inflight != '0);
  assign push     = done_ok | (accept & ~op_normal);
  assign push_data  = done_ok ? unit_data : spec_data;
  assign push_flags = done_ok ? unit_flags : spec_flags;
  assign pop        = out_valid & out_ready;
  assign out_valid  = ~fifo_empty;
  assign out_data   = head_entry[15:0];

`ifdef FPU_FLAGS_EN
  assign push_entry = {push_flags, push_data};
  assign out_flags  = head_entry[EW-1:16];
`else
  logic flags_unused;
  assign push_entry   = push_data;
  assign flags_unused = ^push_flags;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      au_ain    <= '0;
      au_bin    <= '0;
      au_select <= 1'b0;
      au_start  <= 1'b0;
      inflight  <= '0;
      drain     <= DW'(AU_LAT);
    end else begin
      au_start <= issue;
      if (issue) begin
        au_ain    <= in_a;
        au_bin    <= in_b;
        au_select <= in_sel;
      end
      case ({issue, done_ok})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      if (drain != '0) begin
        drain <= drain - DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(done_ok && fifo_full));
    end
  end

  fpu16_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_fpu16_addsub_issue.sv
// Bench for fpu16_addsub_issue: behavioural add/sub unit plus a value-level
// reference model and in-order scoreboard.
module tb_fpu16_addsub_issue;

  localparam int DEPTH  = 4;
  localparam int AU_LAT = 3;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_sel;
  logic [15:0] au_ain;
  logic [15:0] au_bin;
  logic        au_select;
  logic        au_start;
  logic [15:0] au_out  = 16'h0000;
  logic        au_done = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
`ifdef FPU_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pops   = 0;
  bit stray  = 1'b0;
  bit rand_done;

  typedef struct {
    int          due;
    logic [15:0] res;
  } unit_op_t;

  unit_op_t    unit_q[$];
  logic [18:0] exp_q[$];
  logic [18:0] mon_e;

  fpu16_addsub_issue #(.DEPTH(DEPTH), .AU_LAT(AU_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sel    (in_sel),
    .au_ain    (au_ain),
    .au_bin    (au_bin),
    .au_select (au_select),
    .au_start  (au_start),
    .au_out    (au_out),
    .au_done   (au_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef FPU_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp16_val(input logic [15:0] v);
    real mag = pow2(int'(v[14:10]) - 15) * (1.0 + real'(v[9:0]) / 1024.0);
    return v[15] ? -mag : mag;
  endfunction

  // Round-to-nearest-even into FP16; tiny results flush to signed zero.
  function automatic logic [15:0] to_fp16(input real x);
    logic s = (x < 0.0);
    real  ax = s ? -x : x;
    real  m;
    real  fl;
    int   e = 0;
    int   mi;
    if (ax == 0.0) return 16'h0000;
    while (ax >= pow2(e + 1)) e++;
    while (ax < pow2(e)) e--;
    if (e < -14) return {s, 15'b0};
    m  = ax / pow2(e) * 1024.0;
    fl = $floor(m);
    if ((m - fl > 0.5) || ((m - fl == 0.5) && (int'(fl) % 2 == 1))) fl = fl + 1.0;
    mi = int'(fl);
    if (mi == 2048) begin
      mi = 1024;
      e++;
    end
    if (e > 15) return {s, 5'h1F, 10'h000};
    return {s, 5'(e + 15), 10'(mi - 1024)};
  endfunction

  function automatic bit is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'd0);
  endfunction

  function automatic bit is_inf(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] == 10'd0);
  endfunction

  function automatic bit is_zero(input logic [15:0] v);
    return v[14:10] == 5'd0;
  endfunction

  // Expected {INV,OVF,SPC, data} for one op.
  function automatic logic [18:0] ref_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [15:0] e = {b[15] ^ s, b[14:0]};
    logic [15:0] r;
    if (is_nan(a) || is_nan(e) || (is_inf(a) && is_inf(e) && a[15] != e[15])) return {3'b100, 16'h7E00};
    if (is_inf(a)) return {3'b001, a};
    if (is_inf(e)) return {3'b001, e};
    if (is_zero(a) && is_zero(e)) return {3'b001, a[15] & e[15], 15'b0};
    if (is_zero(a)) return {3'b001, e};
    if (is_zero(e)) return {3'b001, a};
    r = to_fp16(fp16_val(a) + fp16_val(e));
    if (is_inf(r)) return {3'b010, r};
    return {3'b000, r};
  endfunction

  function automatic logic [15:0] rand_norm();
    return {1'($urandom_range(0, 1)), 5'($urandom_range(8, 22)), 10'($urandom_range(0, 1023))};
  endfunction

  function automatic logic [15:0] rand_op();
    logic       s = 1'($urandom_range(0, 1));
    logic [9:0] m = 10'($urandom_range(0, 1023));
    int         k = $urandom_range(0, 9);
    case (k)
      0:       return {s, 5'd0, m};
      1:       return {s, 5'h1F, 10'd0};
      2:       return {s, 5'h1F, m | 10'd1};
      default: return {s, 5'($urandom_range(1, 30)), m};
    endcase
  endfunction

  // Behavioural add/sub unit: result appears AU_LAT cycles after the start cycle.
  always @(negedge clk) begin
    if (au_start === 1'b1) begin
      unit_q.push_back('{due: cyc + AU_LAT,
                         res: to_fp16(fp16_val(au_ain) + fp16_val({au_bin[15] ^ au_select, au_bin[14:0]}))});
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    au_done = stray;
    au_out  = 16'h1234;
    if (unit_q.size() != 0 && unit_q[0].due == cyc) begin
      au_done = 1'b1;
      au_out  = unit_q[0].res;
      void'(unit_q.pop_front());
    end
  end

  always @(negedge clk) begin
    #3;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(mon_e[15:0]));
`ifdef FPU_FLAGS_EN
        check("out_flags", 32'(out_flags), 32'(mon_e[18:16]));
`endif
        pops++;
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input bit expect_out, output int waited);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sel   = s;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept_bound", 32'(in_ready), 32'd1);
    if (expect_out) exp_q.push_back(ref_op(a, b, s));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waited   = n;
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic measure(output int first_start, output int starts, output int first_ov);
    first_start = -1;
    starts      = 0;
    first_ov    = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (au_start) begin
        starts++;
        if (first_start < 0) first_start = k;
      end
      if (out_valid && first_ov < 0) first_ov = k;
    end
  endtask

  initial begin
    int w;
    int n;
    int fs;
    int st;
    int fo;
    int acc;
    int p0;
    logic [15:0] ops_a [6];
    logic [15:0] ops_b [6];
    logic        ops_s [6];

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 16'h0000;
    in_b      = 16'h0000;
    in_sel    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_au_start", 32'(au_start), 32'd0);
    check("rst_au_ain", 32'(au_ain), 32'd0);
    check("rst_au_bin", 32'(au_bin), 32'd0);
    check("rst_au_select", 32'(au_select), 32'd0);

    @(negedge clk);
    rst  = 1'b0;
    in_a = 16'h3C00;
    in_b = 16'h3C00;
    #1;
    n = 0;
    while (!in_ready && n < 10) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("drain_cycles", 32'(n), 32'(AU_LAT));

    // 1.0 + 1.0 latency profile
    send(16'h3C00, 16'h3C00, 1'b0, 1'b1, w);
    check("t1_wait", 32'(w), 32'd0);
    measure(fs, st, fo);
    check("t1_first_start", 32'(fs), 32'd1);
    check("t1_start_count", 32'(st), 32'd1);
    check("t1_out_latency", 32'(fo), 32'(AU_LAT + 2));
    wait_empty("t1_drain");

    send(16'h3C00, 16'h3C00, 1'b1, 1'b1, w);
    send(16'h4200, 16'h3C00, 1'b1, 1'b1, w);
    check("t2_back_to_back", 32'(w), 32'd0);
    wait_empty("t2_drain");

    send(16'h7C00, 16'hFC00, 1'b0, 1'b1, w);
    measure(fs, st, fo);
    check("t3_start_count", 32'(st), 32'd0);
    check("t3_out_latency", 32'(fo), 32'd1);
    wait_empty("t3_drain");

    send(16'h7BFF, 16'h7BFF, 1'b0, 1'b1, w);
    wait_empty("t4_drain");

    // special op behind a normal one waits for the unit to empty
    send(16'h3C00, 16'h3C00, 1'b0, 1'b1, w);
    send(16'h0000, 16'h4000, 1'b0, 1'b1, w);
    check("t5_special_wait", 32'(w), 32'(AU_LAT + 1));
    wait_empty("t5_drain");

    // stalled consumer: only DEPTH ops get in
    for (int i = 0; i < 6; i++) begin
      ops_a[i] = rand_norm();
      ops_b[i] = rand_norm();
      ops_s[i] = 1'($urandom_range(0, 1));
    end
    p0        = pops;
    out_ready = 1'b0;
    acc       = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (acc < 6) begin
        in_valid = 1'b1;
        in_a     = ops_a[acc];
        in_b     = ops_b[acc];
        in_sel   = ops_s[acc];
        #1;
        if (in_ready) begin
          exp_q.push_back(ref_op(ops_a[acc], ops_b[acc], ops_s[acc]));
          acc++;
        end
      end
    end
    check("t6_accepted", 32'(acc), 32'(DEPTH));
    check("t6_ready_full", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 4; i < 6; i++) send(ops_a[i], ops_b[i], ops_s[i], 1'b1, w);
    wait_empty("t6_drain");
    check("t6_pop_count", 32'(pops - p0), 32'd6);

    // randomized mix with a bursty consumer
    p0        = pops;
    rand_done = 1'b0;
    fork
      begin
        for (int r = 0; r < 60; r++) begin
          send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'b1, w);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_empty("rand_drain");
    check("rand_pop_count", 32'(pops - p0), 32'd60);

    // reset with two ops in flight
    p0 = pops;
    send(16'h3C00, 16'h4000, 1'b0, 1'b0, w);
    send(16'h4200, 16'h3C00, 1'b0, 1'b0, w);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    stray = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 10) begin
      n++;
      @(negedge clk);
      #1;
    end
    stray = 1'b0;
    check("t7_drain_cycles", 32'(n), 32'(AU_LAT));
    fo = 0;
    st = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) fo++;
      if (au_start) st++;
    end
    check("t7_no_outputs", 32'(fo), 32'd0);
    check("t7_no_starts", 32'(st), 32'd0);
    check("t7_no_pops", 32'(pops - p0), 32'd0);

    send(16'h3C00, 16'h3C00, 1'b0, 1'b1, w);
    wait_empty("t7_recover");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
